// File: rtl/bsr_pkg.sv
// Shared constants for the bidirectional shift-register serializer and its SIPO consumer.
package bsr_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } bsr_state_e;

   localparam logic MODE_LEFT  = 1'b1;
   localparam logic MODE_RIGHT = 1'b0;

   // Bit-counter width; never narrower than one bit.
   function automatic int cnt_width(input int w);
      return (w > 2) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/bsr_bit_cnt.sv
// Modulo-WIDTH bit counter with synchronous clear and enable; flags the last position.
module bsr_bit_cnt
   import bsr_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic clk,
   input  logic rst_ni,
   input  logic clr_i,
   input  logic en_i,
   output logic last_o
);

   localparam int CW = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST_VAL = CW'(WIDTH - 1);

   logic [CW-1:0] cnt_q;

   assign last_o = (cnt_q == LAST_VAL);

   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else if (clr_i) begin
         cnt_q <= '0;
      end else if (en_i) begin
         cnt_q <= last_o ? '0 : cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/bsr_piso_serializer.sv
// Parallel-in serial-out feeder for the bidirectional SIPO; optional stall input
// is enabled with `define BSR_SER_STALL_EN.
module bsr_piso_serializer
   import bsr_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] pin,
   input  logic             dir,
`ifdef BSR_SER_STALL_EN
   input  logic             stall,
`endif
   output logic             sout,
   output logic             mode_out,
   output logic             busy,
   output logic             frame_done
);

   bsr_state_e       state_q;
   logic [WIDTH-1:0] shreg_q;
   logic             sout_q;
   logic             mode_q;

   logic stall_w;
   logic shifting;
   logic advance;
   logic cnt_last;
   logic accept;

`ifdef BSR_SER_STALL_EN
   assign stall_w = stall;
`else
   assign stall_w = 1'b0;
`endif

   assign shifting = (state_q == ST_SHIFT);
   assign advance  = shifting && !stall_w;

   // The last-bit cycle doubles as an accept slot so frames can run back to back.
   assign load_ready = (state_q == ST_IDLE) || (advance && cnt_last);
   assign accept     = load_valid && load_ready;

   assign sout       = sout_q;
   assign mode_out   = mode_q;
   assign busy       = shifting;
   assign frame_done = advance && cnt_last;

   bsr_bit_cnt #(
      .WIDTH (WIDTH)
   ) u_bit_cnt (
      .clk    (clk),
      .rst_ni (rst),
      .clr_i  (accept || (advance && cnt_last)),
      .en_i   (advance && !cnt_last),
      .last_o (cnt_last)
   );

   // The word is shifted toward the output end, so the next bit always sits next to it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         shreg_q <= '0;
         sout_q  <= 1'b0;
         mode_q  <= 1'b0;
      end else if (accept) begin
         state_q <= ST_SHIFT;
         shreg_q <= pin;
         mode_q  <= dir;
         sout_q  <= (dir == MODE_LEFT) ? pin[WIDTH-1] : pin[0];
      end else if (advance) begin
         if (cnt_last) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            sout_q  <= 1'b0;
         end else if (mode_q == MODE_LEFT) begin
            shreg_q <= {shreg_q[WIDTH-2:0], 1'b0};
            sout_q  <= shreg_q[WIDTH-2];
         end else begin
            shreg_q <= {1'b0, shreg_q[WIDTH-1:1]};
            sout_q  <= shreg_q[1];
         end
      end
   end

endmodule

// File: tb/tb_bsr_piso_serializer.sv
// Self-checking bench for bsr_piso_serializer: queue-based bit model plus downstream SIPO.
module tb_bsr_piso_serializer;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       load_valid = 1'b0;
   logic [3:0] pin = 4'b0000;
   logic       dir = 1'b0;
   logic       stall = 1'b0;
   logic       load_ready, sout, mode_out, busy, frame_done;

   int checks = 0;
   int failures = 0;

   bsr_piso_serializer #(.WIDTH(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .pin        (pin),
      .dir        (dir),
`ifdef BSR_SER_STALL_EN
      .stall      (stall),
`endif
      .sout       (sout),
      .mode_out   (mode_out),
      .busy       (busy),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Model: queue of bits still to appear on sout, head is the bit currently on the wire.
   bit mq[$];
   bit m_mode = 1'b0;

   initial forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
         mq.delete();
         m_mode = 1'b0;
      end else begin
         bit stl, rdy;
         stl = stall && (mq.size() > 0);
         rdy = (mq.size() == 0) || (mq.size() == 1 && !stl);
         if (mq.size() > 0 && !stl) void'(mq.pop_front());
         if (load_valid && rdy) begin
            for (int i = 0; i < 4; i++) mq.push_back(dir ? pin[3-i] : pin[i]);
            m_mode = dir;
         end
      end
   end

   // Downstream SIPO and a log of every delivered bit and frame_done flag.
   logic [3:0] pout = 4'b0000;
   logic [7:0] logv = 8'h00;
   logic [7:0] fdv = 8'h00;
   int         logn = 0;

   initial forever begin
      @(posedge clk);
      if (rst && busy && !stall) begin
         pout = mode_out ? {pout[2:0], sout} : {sout, pout[3:1]};
         logv = {logv[6:0], sout};
         fdv  = {fdv[6:0], frame_done};
         logn++;
      end
   end

   initial forever begin
      @(negedge clk);
      begin
         bit stl;
         stl = stall && (mq.size() > 0);
         chk("cyc_sout", {7'b0, sout}, {7'b0, (mq.size() > 0) ? mq[0] : 1'b0});
         chk("cyc_mode", {7'b0, mode_out}, {7'b0, m_mode});
         chk("cyc_busy", {7'b0, busy}, {7'b0, mq.size() > 0});
         chk("cyc_done", {7'b0, frame_done}, {7'b0, (mq.size() == 1) && !stl});
         chk("cyc_ready", {7'b0, load_ready},
             {7'b0, (mq.size() == 0) || (mq.size() == 1 && !stl)});
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic send(input logic [3:0] p, input logic d);
      load_valid = 1'b1;
      pin = p;
      dir = d;
      step();
      load_valid = 1'b0;
   endtask

   task automatic clr_log();
      logv = 8'h00;
      fdv  = 8'h00;
      logn = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0;
      repeat (3) step();
      chk("rst_sout", {7'b0, sout}, 8'h00);
      chk("rst_mode", {7'b0, mode_out}, 8'h00);
      chk("rst_busy", {7'b0, busy}, 8'h00);
      chk("rst_done", {7'b0, frame_done}, 8'h00);
      chk("rst_ready", {7'b0, load_ready}, 8'h01);
      rst = 1'b1;
      step();

      clr_log();
      send(4'b1010, 1'b1);
      repeat (5) step();
      $display("frame pin=1010 dir=1 bits=%b pout=%b", logv[3:0], pout);
      chk("f1_n", 8'(logn), 8'd4);
      chk("f1_bits", {4'b0, logv[3:0]}, 8'b0000_1010);
      chk("f1_done", {4'b0, fdv[3:0]}, 8'b0000_0001);
      chk("f1_pout", {4'b0, pout}, 8'b0000_1010);

      clr_log();
      send(4'b1101, 1'b0);
      repeat (5) step();
      $display("frame pin=1101 dir=0 bits=%b pout=%b", logv[3:0], pout);
      chk("f2_n", 8'(logn), 8'd4);
      chk("f2_bits", {4'b0, logv[3:0]}, 8'b0000_1011);
      chk("f2_pout", {4'b0, pout}, 8'b0000_1101);

      clr_log();
      load_valid = 1'b1;
      pin = 4'b1100;
      dir = 1'b1;
      step();
      pin = 4'b0011;
      dir = 1'b0;
      repeat (4) step();
      load_valid = 1'b0;
      repeat (5) step();
      $display("b2b 1100/1 + 0011/0 bits=%b done=%b pout=%b", logv, fdv, pout);
      chk("b2b_n", 8'(logn), 8'd8);
      chk("b2b_bits", logv, 8'b1100_1100);
      chk("b2b_done", fdv, 8'b0001_0001);
      chk("b2b_pout", {4'b0, pout}, 8'b0000_0011);

      clr_log();
      send(4'b0000, 1'b1);
      load_valid = 1'b1;
      pin = 4'b1111;
      dir = 1'b0;
      step();
      chk("ign_ready1", {7'b0, load_ready}, 8'h00);
      step();
      chk("ign_ready2", {7'b0, load_ready}, 8'h00);
      load_valid = 1'b0;
      repeat (4) step();
      $display("ignore pin=0000 with stray 1111 bits=%b pout=%b", logv[3:0], pout);
      chk("ign_n", 8'(logn), 8'd4);
      chk("ign_bits", {4'b0, logv[3:0]}, 8'h00);
      chk("ign_pout", {4'b0, pout}, 8'h00);

      clr_log();
      send(4'b1011, 1'b1);
      step();
      step();
      rst = 1'b0;
      #1;
      $display("abort pin=1011 after %0d bits", logn);
      chk("abt_sout", {7'b0, sout}, 8'h00);
      chk("abt_busy", {7'b0, busy}, 8'h00);
      chk("abt_mode", {7'b0, mode_out}, 8'h00);
      chk("abt_done", {7'b0, frame_done}, 8'h00);
      chk("abt_bits", {6'b0, logv[1:0]}, 8'b0000_0010);
      step();
      step();
      rst = 1'b1;
      step();
      clr_log();
      send(4'b0110, 1'b0);
      repeat (5) step();
      $display("frame pin=0110 dir=0 bits=%b pout=%b", logv[3:0], pout);
      chk("post_bits", {4'b0, logv[3:0]}, 8'b0000_0110);
      chk("post_pout", {4'b0, pout}, 8'b0000_0110);

`ifdef BSR_SER_STALL_EN
      clr_log();
      send(4'b1001, 1'b1);
      step();
      stall = 1'b1;
      step();
      chk("stl_done", {7'b0, frame_done}, 8'h00);
      chk("stl_ready", {7'b0, load_ready}, 8'h00);
      chk("stl_sout", {7'b0, sout}, 8'h00);
      step();
      step();
      stall = 1'b0;
      step();
      chk("stl_done_early", {7'b0, frame_done}, 8'h00);
      step();
      chk("stl_done_late", {7'b0, frame_done}, 8'h01);
      chk("stl_last", {7'b0, sout}, 8'h01);
      repeat (3) step();
      $display("stall pin=1001 dir=1 bits=%b pout=%b", logv[3:0], pout);
      chk("stl_bits", {4'b0, logv[3:0]}, 8'b0000_1001);
      chk("stl_pout", {4'b0, pout}, 8'b0000_1001);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
